// File: rtl/axi_rd_responder_if.sv
// rtl/axi_rd_responder_if.sv - AXI read channel plus backing RAM port bundle
//
// Signals:
//   araddr/arlen/arvalid/arready   read-address handshake (INCR, 4-byte beats)
//   rdata/rlast/rvalid/rready      read-data handshake
//   mem_en/mem_addr/mem_rdata      synchronous RAM port, data one cycle after mem_en
// Modports:
//   slave   responder view (drives arready, r*, mem_en, mem_addr)
//   master  initiator + RAM view (drives ar*, rready, mem_rdata)

interface axi_rd_responder_if #(
    parameter int MEM_INDEX_WIDTH = 10
);
    logic [31:0]                araddr;
    logic [7:0]                 arlen;
    logic                       arvalid;
    logic                       arready;
    logic [31:0]                rdata;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;
    logic                       mem_en;
    logic [MEM_INDEX_WIDTH-1:0] mem_addr;
    logic [31:0]                mem_rdata;

    modport slave (
        input  araddr, arlen, arvalid, rready, mem_rdata,
        output arready, rdata, rlast, rvalid, mem_en, mem_addr
    );

    modport master (
        output araddr, arlen, arvalid, rready, mem_rdata,
        input  arready, rdata, rlast, rvalid, mem_en, mem_addr
    );
endinterface

// File: rtl/axi_rd_responder.sv
// rtl/axi_rd_responder.sv - AXI INCR read burst responder backed by a synchronous RAM
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  axi_rd_responder_if.slave (AR/R handshakes and RAM read port)
//
// One burst at a time. RAM reads are issued under a 2-credit rule
// (buffered beats + in-flight reads < 2) so the 2-entry FIFO can never
// overflow. When the FIFO is empty the returning RAM word is presented
// directly on rdata, which gives first rvalid two cycles after the AR
// handshake and one beat per cycle under full rready.

module axi_rd_responder #(
    parameter int MEM_INDEX_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_rd_responder_if.slave    bus
);

    localparam logic [MEM_INDEX_WIDTH-1:0] PTR_ONE = {{(MEM_INDEX_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [MEM_INDEX_WIDTH-1:0] r_ptr;
    logic [7:0]                 r_issue_cnt;
    logic                       r_issue_done;
    logic                       r_inflight;
    logic                       r_inflight_last;

    logic [31:0]                r_fifo_data [2];
    logic [1:0]                 r_fifo_last;
    logic                       r_wr_idx;
    logic                       r_rd_idx;
    logic [1:0]                 r_count;

    logic                       w_arready;
    logic                       w_ar_hs;
    logic                       w_fifo_empty;
    logic                       w_credit_ok;
    logic                       w_issue;
    logic                       w_rvalid;
    logic [31:0]                w_head_data;
    logic                       w_head_last;
    logic                       w_pop;
    logic                       w_pop_fifo;
    logic                       w_push;
    logic                       w_last_hs;
    logic                       w_unused;

    // Byte-lane and above-RAM address bits are don't-care.
    assign w_unused = ^{bus.araddr[31:MEM_INDEX_WIDTH+2], bus.araddr[1:0]};

    assign w_fifo_empty = (r_count == 2'd0);
    assign w_credit_ok  = (r_count == 2'd0) || ((r_count == 2'd1) && !r_inflight);

    // Empty FIFO with a read in flight: the RAM output is the head beat.
    assign w_rvalid    = !rst && (!w_fifo_empty || r_inflight);
    assign w_head_data = w_fifo_empty ? bus.mem_rdata   : r_fifo_data[r_rd_idx];
    assign w_head_last = w_fifo_empty ? r_inflight_last : r_fifo_last[r_rd_idx];

    assign w_pop      = w_rvalid && bus.rready;
    assign w_pop_fifo = w_pop && !w_fifo_empty;
    // A bypassed beat consumed in its arrival cycle never enters the FIFO.
    assign w_push     = r_inflight && !(w_pop && w_fifo_empty);
    assign w_last_hs  = w_pop && w_head_last;

    assign w_ar_hs = w_arready && bus.arvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_arready    = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_arready = !rst;
                if (!rst && bus.arvalid) begin
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                w_issue = !rst && !r_issue_done && w_credit_ok;
                if (w_last_hs) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr           <= '0;
            r_issue_cnt     <= 8'd0;
            r_issue_done    <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= 32'd0;
            end
            r_fifo_last <= 2'b00;
            r_wr_idx    <= 1'b0;
            r_rd_idx    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_ar_hs) begin
                r_ptr        <= bus.araddr[MEM_INDEX_WIDTH+1:2];
                r_issue_cnt  <= bus.arlen;
                r_issue_done <= 1'b0;
            end else if (w_issue) begin
                r_ptr <= r_ptr + PTR_ONE;
                if (r_issue_cnt == 8'd0) begin
                    r_issue_done <= 1'b1;
                end else begin
                    r_issue_cnt <= r_issue_cnt - 8'd1;
                end
            end

            // The read issued with zero remaining count is beat number arlen.
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issue_cnt == 8'd0);

            if (w_push) begin
                r_fifo_data[r_wr_idx] <= bus.mem_rdata;
                r_fifo_last[r_wr_idx] <= r_inflight_last;
                r_wr_idx              <= !r_wr_idx;
            end
            if (w_pop_fifo) begin
                r_rd_idx <= !r_rd_idx;
            end

            case ({w_push, w_pop_fifo})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.arready  = w_arready;
    assign bus.rvalid   = w_rvalid;
    assign bus.rdata    = w_rvalid ? w_head_data : 32'd0;
    assign bus.rlast    = w_rvalid && w_head_last;
    assign bus.mem_en   = w_issue;
    assign bus.mem_addr = w_issue ? r_ptr : '0;

endmodule

// File: tb/tb_axi_rd_responder.sv
// tb/tb_axi_rd_responder.sv - directed table-driven bench for axi_rd_responder

module tb_axi_rd_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    axi_rd_responder_if #(.MEM_INDEX_WIDTH(10)) bus ();

    axi_rd_responder #(.MEM_INDEX_WIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: word k holds 0xA000_0000 + k, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= 32'hA000_0000 + {22'd0, bus.mem_addr};
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        int          mode;       // 0: rready always 1, 1: rready 1,0,0,1,...
        bit          hold;       // keep arvalid high (0x40, len 1) during the burst
        logic [9:0]  first_word;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_burst(input logic [31:0] addr, input logic [7:0] len);
        int n;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arvalid = 1'b1;
        #1;
        n = 0;
        while (!bus.arready && n < 50) begin
            step();
            n++;
        end
        check("ar_accept", {31'd0, bus.arready}, 32'd1);
    endtask

    task automatic run_burst(input vec_t v);
        int         cyc;
        int         beat;
        int         issued;
        int         consumed;
        int         last_cyc;
        logic [9:0] exp_ptr;
        logic [9:0] exp_word;
        logic       prev_stall;
        logic [31:0] prev_data;
        logic       prev_last;

        cyc        = 0;
        beat       = 0;
        issued     = 0;
        consumed   = 0;
        last_cyc   = -1;
        exp_ptr    = v.first_word;
        prev_stall = 1'b0;
        prev_data  = 32'd0;
        prev_last  = 1'b0;

        start_burst(v.addr, v.len);

        while (last_cyc < 0 && cyc < 200) begin
            step();
            cyc++;
            if (v.hold) begin
                bus.araddr  = 32'h0000_0040;
                bus.arlen   = 8'd1;
                bus.arvalid = 1'b1;
            end else begin
                bus.arvalid = 1'b0;
            end
            if (v.mode == 0) bus.rready = 1'b1;
            else             bus.rready = (cyc >= 2) && (((cyc - 2) % 3) == 0);

            check("arready_busy", {31'd0, bus.arready}, 32'd0);
            check("rlast_without_rvalid", {31'd0, bus.rlast & ~bus.rvalid}, 32'd0);

            if (bus.mem_en) begin
                check("credit_outstanding", {31'd0, (issued - consumed) < 2}, 32'd1);
                check("mem_addr", {22'd0, bus.mem_addr}, {22'd0, exp_ptr});
                exp_ptr = exp_ptr + 10'd1;
                issued++;
            end

            if (v.mode == 0 && cyc == 1) begin
                check("first_mem_en", {31'd0, bus.mem_en}, 32'd1);
            end
            if (v.mode == 0 && cyc <= v.len + 2) begin
                check("rvalid_timing", {31'd0, bus.rvalid}, (cyc >= 2) ? 32'd1 : 32'd0);
            end

            if (prev_stall) begin
                check("stall_rvalid", {31'd0, bus.rvalid}, 32'd1);
                check("stall_rdata", bus.rdata, prev_data);
                check("stall_rlast", {31'd0, bus.rlast}, {31'd0, prev_last});
            end

            if (bus.rvalid && bus.rready) begin
                exp_word = v.first_word + beat[9:0];
                check("beat_rdata", bus.rdata, 32'hA000_0000 + {22'd0, exp_word});
                check("beat_rlast", {31'd0, bus.rlast}, (beat == int'(v.len)) ? 32'd1 : 32'd0);
                consumed++;
                beat++;
                if (bus.rlast) last_cyc = cyc;
            end

            prev_stall = bus.rvalid & ~bus.rready;
            prev_data  = bus.rdata;
            prev_last  = bus.rlast;
        end

        check("burst_done", {31'd0, last_cyc >= 0}, 32'd1);
        if (v.mode == 0) check("last_hs_cycle", last_cyc, v.len + 2);
        check("beat_count", beat, v.len + 1);
        check("issue_count", issued, v.len + 1);

        step();
        if (!v.hold) bus.arvalid = 1'b0;
        check("arready_back", {31'd0, bus.arready}, 32'd1);
        check("rvalid_after", {31'd0, bus.rvalid}, 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{addr: 32'h0000_0010, len: 8'd3, mode: 0, hold: 1'b0, first_word: 10'h004};
        vecs[1] = '{addr: 32'h0000_0FF8, len: 8'd3, mode: 0, hold: 1'b0, first_word: 10'h3FE};
        vecs[2] = '{addr: 32'h0000_0100, len: 8'd7, mode: 1, hold: 1'b0, first_word: 10'h040};
        vecs[3] = '{addr: 32'h0000_0020, len: 8'd0, mode: 0, hold: 1'b1, first_word: 10'h008};
        vecs[4] = '{addr: 32'h0000_0040, len: 8'd1, mode: 0, hold: 1'b0, first_word: 10'h010};
        vecs[5] = '{addr: 32'hFFFF_F004, len: 8'd2, mode: 1, hold: 1'b0, first_word: 10'h001};

        rst           = 1'b1;
        bus.araddr    = 32'd0;
        bus.arlen     = 8'd0;
        bus.arvalid   = 1'b0;
        bus.rready    = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;

        step();
        step();
        check("rst_arready",  {31'd0, bus.arready}, 32'd0);
        check("rst_rvalid",   {31'd0, bus.rvalid},  32'd0);
        check("rst_rlast",    {31'd0, bus.rlast},   32'd0);
        check("rst_mem_en",   {31'd0, bus.mem_en},  32'd0);
        check("rst_rdata",    bus.rdata,            32'd0);
        check("rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_arready", {31'd0, bus.arready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i]);
        end

        // Reset in the middle of a 16-beat burst.
        start_burst(32'h0000_0200, 8'd15);
        step();
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        step();
        check("mid_rvalid_t2", {31'd0, bus.rvalid}, 32'd1);
        check("mid_rdata_t2",  bus.rdata, 32'hA000_0080);
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_arready",  {31'd0, bus.arready}, 32'd0);
        check("mid_rst_rvalid",   {31'd0, bus.rvalid},  32'd0);
        check("mid_rst_mem_en",   {31'd0, bus.mem_en},  32'd0);
        check("mid_rst_rdata",    bus.rdata,            32'd0);
        check("mid_rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("after_rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
        check("after_rst_rlast",   {31'd0, bus.rlast},   32'd0);
        check("after_rst_arready", {31'd0, bus.arready}, 32'd1);
        check("after_rst_mem_en",  {31'd0, bus.mem_en},  32'd0);
        bus.rready = 1'b0;
        step();
        check("stale_ram_dropped", {31'd0, bus.rvalid}, 32'd0);
        run_burst('{addr: 32'h0000_0080, len: 8'd1, mode: 0, hold: 1'b0, first_word: 10'h020});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
